// File: rtl/shift_sequencer.sv
// Two-requester round-robin front end for a one-bit-per-cycle left shifter.
// A granted word is shifted by its amount, then presented on the result channel with its requester ID.
module shift_sequencer #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_data,
    input  logic [SW-1:0] req0_amt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_data,
    input  logic [SW-1:0] req1_amt,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic          res_id,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  data_q;
    logic [SW-1:0] cnt_q;
    logic          id_q;
    logic          last_q;

    logic          grant0;
    logic          grant1;
    logic          accept0;
    logic          accept1;
    logic [W-1:0]  data_sel;
    logic [SW-1:0] amt_sel;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0   = req0_valid & (~req1_valid | last_q);
        grant1   = req1_valid & (~req0_valid | ~last_q);
        accept0  = (state == IDLE) & grant0;
        accept1  = (state == IDLE) & grant1;
        data_sel = accept1 ? req1_data : req0_data;
        amt_sel  = accept1 ? req1_amt  : req0_amt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept0 | accept1) begin
                    state_next = (amt_sel == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == SW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept0;
        req1_ready = accept1;
        res_valid  = (state == DONE);
        res_data   = data_q;
        res_id     = id_q;
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
        end else if (accept0 | accept1) begin
            data_q <= data_sel;
            cnt_q  <= amt_sel;
            id_q   <= accept1;
            last_q <= accept1;
        end else if (state == SHIFT) begin
            data_q <= {data_q[W-2:0], 1'b0};
            cnt_q  <= cnt_q - SW'(1);
        end
    end

endmodule
